// File: rtl/spi_slave_shifter.sv
// SPI mode-0 responder shift engine: synchronizes sck/ssN/mosi into the clockIn
// domain, shifts bytes MSB-first in on mosi and out on miso, and pulses rxValid per byte.
module spi_slave_shifter #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clockIn,
  input  logic                  reset,
  input  logic                  sck,
  input  logic                  ssN,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  misoEn,
  input  logic [DATA_WIDTH-1:0] txData,
  output logic                  txAck,
  output logic [DATA_WIDTH-1:0] rxData,
  output logic                  rxValid,
  output logic                  busy,
  output logic                  frameError
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  logic [SYNC_STAGES-1:0] r_sckSync;
  logic [SYNC_STAGES-1:0] r_ssSync;
  logic [SYNC_STAGES-1:0] r_mosiSync;
  logic                   r_sckPrev;
  logic                   r_ssPrev;

  state_t                 r_state;
  state_t                 w_stateNext;
  logic [CNT_W-1:0]       r_bitCnt;
  logic                   r_loadNext;
  logic [DATA_WIDTH-2:0]  r_rxShift;
  logic [DATA_WIDTH-1:0]  r_txShift;
  logic [DATA_WIDTH-1:0]  r_rxData;
  logic                   r_rxValid;
  logic                   r_txAck;
  logic                   r_frameError;

  logic                   w_sck;
  logic                   w_ss;
  logic                   w_mosi;
  logic                   w_sckRise;
  logic                   w_sckFall;
  logic                   w_ssRise;
  logic                   w_ssFall;
  logic                   w_loadFrame;
  logic                   w_rxShiftEn;
  logic                   w_txShiftEn;
  logic                   w_txReload;
  logic                   w_abort;
  logic [DATA_WIDTH-1:0]  w_rxNext;

  // ssN chain resets high so a select held low through reset release reads as a new frame.
  always_ff @(posedge clockIn or posedge reset) begin
    if (reset) begin
      r_sckSync  <= '0;
      r_mosiSync <= '0;
      r_ssSync   <= '1;
      r_sckPrev  <= 1'b0;
      r_ssPrev   <= 1'b1;
    end else begin
      r_sckSync  <= {r_sckSync[SYNC_STAGES-2:0], sck};
      r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], mosi};
      r_ssSync   <= {r_ssSync[SYNC_STAGES-2:0], ssN};
      r_sckPrev  <= r_sckSync[SYNC_STAGES-1];
      r_ssPrev   <= r_ssSync[SYNC_STAGES-1];
    end
  end

  assign w_sck     = r_sckSync[SYNC_STAGES-1];
  assign w_ss      = r_ssSync[SYNC_STAGES-1];
  assign w_mosi    = r_mosiSync[SYNC_STAGES-1];
  assign w_sckRise = w_sck & ~r_sckPrev;
  assign w_sckFall = ~w_sck & r_sckPrev;
  assign w_ssRise  = w_ss & ~r_ssPrev;
  assign w_ssFall  = ~w_ss & r_ssPrev;

  always_ff @(posedge clockIn or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // A deselect in SHIFT takes priority over any SCK edge seen in the same cycle.
  always_comb begin
    w_stateNext = r_state;
    w_loadFrame = 1'b0;
    w_rxShiftEn = 1'b0;
    w_txShiftEn = 1'b0;
    w_txReload  = 1'b0;
    w_abort     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_ssFall) begin
          w_stateNext = SHIFT;
          w_loadFrame = 1'b1;
        end
      end
      SHIFT: begin
        if (w_ssRise) begin
          w_stateNext = IDLE;
          w_abort     = 1'b1;
        end else begin
          w_rxShiftEn = w_sckRise;
          w_txReload  = w_sckFall & r_loadNext;
          w_txShiftEn = w_sckFall & ~r_loadNext;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // The shift register keeps only W-1 bits; the completed word is assembled with the last mosi bit.
  assign w_rxNext = {r_rxShift, w_mosi};

  always_ff @(posedge clockIn or posedge reset) begin
    if (reset) begin
      r_bitCnt     <= '0;
      r_loadNext   <= 1'b0;
      r_rxShift    <= '0;
      r_txShift    <= '0;
      r_rxData     <= '0;
      r_rxValid    <= 1'b0;
      r_txAck      <= 1'b0;
      r_frameError <= 1'b0;
    end else begin
      r_rxValid    <= 1'b0;
      r_txAck      <= 1'b0;
      r_frameError <= 1'b0;

      if (w_loadFrame || w_txReload) begin
        r_txShift <= txData;
        r_txAck   <= 1'b1;
      end else if (w_txShiftEn) begin
        r_txShift <= r_txShift << 1;
      end

      if (w_loadFrame) begin
        r_bitCnt   <= '0;
        r_loadNext <= 1'b0;
      end else if (w_abort) begin
        r_bitCnt     <= '0;
        r_loadNext   <= 1'b0;
        r_rxShift    <= '0;
        r_frameError <= (r_bitCnt != '0);
      end else begin
        if (w_txReload) begin
          r_loadNext <= 1'b0;
        end
        if (w_rxShiftEn) begin
          r_rxShift <= w_rxNext[DATA_WIDTH-2:0];
          if (r_bitCnt == LAST_BIT) begin
            r_rxData   <= w_rxNext;
            r_rxValid  <= 1'b1;
            r_bitCnt   <= '0;
            r_loadNext <= 1'b1;
          end else begin
            r_bitCnt <= r_bitCnt + 1'b1;
          end
        end
      end
    end
  end

  assign busy       = (r_state == SHIFT);
  assign misoEn     = busy;
  assign miso       = busy & r_txShift[DATA_WIDTH-1];
  assign txAck      = r_txAck;
  assign rxData     = r_rxData;
  assign rxValid    = r_rxValid;
  assign frameError = r_frameError;

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Directed bench for spi_slave_shifter: drives an SCK = clockIn/4 master and
// checks received bytes through a scoreboard queue plus miso bits and pulse counts.
module tb_spi_slave_shifter;

  localparam int W = 8;

  logic         clockIn = 1'b0;
  logic         reset   = 1'b1;
  logic         sck     = 1'b0;
  logic         ssN     = 1'b1;
  logic         mosi    = 1'b0;
  logic [W-1:0] txData  = '0;
  logic         miso;
  logic         misoEn;
  logic         txAck;
  logic [W-1:0] rxData;
  logic         rxValid;
  logic         busy;
  logic         frameError;

  int n_checks = 0;
  int n_errors = 0;
  int n_txack  = 0;
  int n_rxv    = 0;
  int n_ferr   = 0;

  logic [W-1:0] q_rx[$];

  spi_slave_shifter #(
    .DATA_WIDTH (W),
    .SYNC_STAGES(2)
  ) dut (
    .clockIn   (clockIn),
    .reset     (reset),
    .sck       (sck),
    .ssN       (ssN),
    .mosi      (mosi),
    .miso      (miso),
    .misoEn    (misoEn),
    .txData    (txData),
    .txAck     (txAck),
    .rxData    (rxData),
    .rxValid   (rxValid),
    .busy      (busy),
    .frameError(frameError)
  );

  always #5 clockIn = ~clockIn;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clockIn);
  endtask

  task automatic clear_counts();
    n_txack = 0;
    n_rxv   = 0;
    n_ferr  = 0;
  endtask

  // Master side: mosi changes with the falling SCK, miso is checked late in the high phase.
  task automatic send_bits(input logic [7:0] mo, input int nbits,
                           input logic [7:0] txexp, input bit end_ss);
    if (nbits == 8) q_rx.push_back(mo);
    for (int k = 0; k < nbits; k++) begin
      mosi = mo[7-k];
      tick(2);
      sck = 1'b1;
      tick(2);
      check("miso_bit", {31'b0, miso}, {31'b0, txexp[7-k]});
      sck = 1'b0;
      if (end_ss && (k == nbits - 1)) ssN = 1'b1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_miso"},   {31'b0, miso},       32'd0);
    check({tag, "_misoEn"}, {31'b0, misoEn},     32'd0);
    check({tag, "_busy"},   {31'b0, busy},       32'd0);
    check({tag, "_rxData"}, {24'b0, rxData},     32'd0);
    check({tag, "_rxV"},    {31'b0, rxValid},    32'd0);
    check({tag, "_txAck"},  {31'b0, txAck},      32'd0);
    check({tag, "_fErr"},   {31'b0, frameError}, 32'd0);
  endtask

  always @(negedge clockIn) begin
    if (txAck) n_txack++;
    if (frameError) n_ferr++;
    if (rxValid) begin
      n_rxv++;
      if (q_rx.size() == 0) check("rx_unexpected", {24'b0, rxData}, 32'hFFFF_FFFF);
      else check("rx_scoreboard", {24'b0, rxData}, {24'b0, q_rx.pop_front()});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick(2);
    check_all_zero("reset");
    reset = 1'b0;
    tick(3);

    // Single byte; select released together with the final SCK fall so no reload occurs.
    clear_counts();
    txData = 8'hA5;
    ssN    = 1'b0;
    tick(4);
    check("t1_busy",   {31'b0, busy},   32'd1);
    check("t1_misoEn", {31'b0, misoEn}, 32'd1);
    send_bits(8'h3C, 8, 8'hA5, 1'b1);
    tick(6);
    check("t1_rxv_cnt",   n_rxv,           32'd1);
    check("t1_rxData",    {24'b0, rxData}, 32'h3C);
    check("t1_txack_cnt", n_txack,         32'd1);
    check("t1_ferr_cnt",  n_ferr,          32'd0);
    check("t1_idle_busy", {31'b0, busy},   32'd0);
    check("t1_idle_miso", {31'b0, miso},   32'd0);

    // Two-byte frame with select held low throughout.
    clear_counts();
    txData = 8'h81;
    ssN    = 1'b0;
    tick(4);
    txData = 8'h7E;
    send_bits(8'hF0, 8, 8'h81, 1'b0);
    send_bits(8'h0F, 8, 8'h7E, 1'b0);
    tick(4);
    ssN = 1'b1;
    tick(6);
    check("t2_rxv_cnt",   n_rxv,           32'd2);
    check("t2_rxData",    {24'b0, rxData}, 32'h0F);
    check("t2_txack_cnt", n_txack,         32'd3);
    check("t2_ferr_cnt",  n_ferr,          32'd0);

    // Abort after five bits.
    clear_counts();
    txData = 8'h55;
    ssN    = 1'b0;
    tick(4);
    send_bits(8'hB7, 5, 8'h55, 1'b0);
    tick(2);
    ssN = 1'b1;
    tick(4);
    check("t3_busy",     {31'b0, busy},   32'd0);
    tick(2);
    check("t3_ferr_cnt", n_ferr,          32'd1);
    check("t3_rxv_cnt",  n_rxv,           32'd0);
    check("t3_rxData",   {24'b0, rxData}, 32'h0F);
    check("t3_miso",     {31'b0, miso},   32'd0);

    // SCK activity with the select inactive.
    clear_counts();
    for (int p = 0; p < 10; p++) begin
      mosi = p[0];
      sck  = 1'b1;
      tick(2);
      sck = 1'b0;
      tick(2);
      check("t4_misoEn", {31'b0, misoEn}, 32'd0);
    end
    tick(4);
    check("t4_rxv_cnt",   n_rxv,         32'd0);
    check("t4_txack_cnt", n_txack,       32'd0);
    check("t4_miso",      {31'b0, miso}, 32'd0);

    // Reset mid-frame with the select kept low across release.
    clear_counts();
    txData = 8'hC3;
    ssN    = 1'b0;
    tick(4);
    send_bits(8'hA0, 3, 8'hC3, 1'b0);
    tick(1);
    reset = 1'b1;
    tick(1);
    check_all_zero("t5_rst");
    tick(2);
    reset = 1'b0;
    clear_counts();
    tick(5);
    check("t5_txack_cnt", n_txack,       32'd1);
    check("t5_busy",      {31'b0, busy}, 32'd1);
    send_bits(8'h5A, 8, 8'hC3, 1'b0);
    tick(4);
    check("t5_rxv_cnt", n_rxv,           32'd1);
    check("t5_rxData",  {24'b0, rxData}, 32'h5A);
    ssN = 1'b1;
    tick(6);
    check("t5_ferr_cnt",   n_ferr,  32'd0);
    check("t5_txack_cnt2", n_txack, 32'd2);

    // Select rises together with the eighth SCK rise: the edge is lost.
    clear_counts();
    txData = 8'hFF;
    ssN    = 1'b0;
    tick(4);
    send_bits(8'h69, 7, 8'hFF, 1'b0);
    mosi = 1'b1;
    tick(2);
    sck = 1'b1;
    ssN = 1'b1;
    tick(4);
    sck = 1'b0;
    tick(4);
    check("t6_ferr_cnt", n_ferr,          32'd1);
    check("t6_rxv_cnt",  n_rxv,           32'd0);
    check("t6_rxData",   {24'b0, rxData}, 32'h5A);
    check("t6_busy",     {31'b0, busy},   32'd0);

    check("scoreboard_empty", q_rx.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
